// File: rtl/cloud_render.sv
// Cloud sprite renderer: three 48x16 clouds with vblank-only position capture
// and a two-stage pixel pipeline aligned with video_on.
module cloud_render #(
  parameter int CLOUD_W  = 48,
  parameter int CLOUD_H  = 16,
  parameter int CLOUD_Y0 = 60,
  parameter int CLOUD_Y1 = 90,
  parameter int CLOUD_Y2 = 70,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int PARK_X   = 750
) (
  input  logic        clk_25MHz,
  input  logic        rst_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        video_on,
  input  logic [10:0] hc0,
  input  logic [10:0] hc1,
  input  logic [10:0] hc2,
  output logic        cloud_pix,
  output logic [1:0]  cloud_id,
  output logic        video_on_d,
  output logic        pos_stale
);

  localparam int C_BITS = 6;  // sprite bitmap is fixed at 48 columns
  localparam int R_BITS = 4;  // and 16 rows
  localparam logic [11:0] W12    = 12'(CLOUD_W);
  localparam logic [10:0] H11    = 11'(CLOUD_H);
  localparam logic [11:0] HIDE_X = 12'(H_ACTIVE + CLOUD_W);
  localparam logic [10:0] PARK   = 11'(PARK_X);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE);
  localparam logic [2:0][10:0] Y_TOP = {11'(CLOUD_Y2), 11'(CLOUD_Y1), 11'(CLOUD_Y0)};
  localparam logic [2:0]  MAX_FAIL = 3'd7;

  typedef enum logic [1:0] {IDLE, SAMPLE, CHECK, COMMIT} cap_state_t;

  cap_state_t  state;
  logic [2:0]  retry;
  logic [10:0] s [3];
  logic [10:0] t [3];
  logic        hc_match;

  assign hc_match = (hc0 == t[0]) && (hc1 == t[1]) && (hc2 == t[2]);

  // Capture FSM: sample the scroller positions twice during vblank and commit
  // only when they agree, so the visible frame always renders from stable shadows.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      retry     <= '0;
      pos_stale <= 1'b0;
      // NOTE: shadow/trial positions are only three registers each, so they are
      // reset explicitly; clouds must start parked rather than at random columns.
      for (int k = 0; k < 3; k++) begin
        s[k] <= PARK;
        t[k] <= PARK;
      end
    end else if (state != IDLE && vcount == '0) begin
      state     <= IDLE;
      pos_stale <= 1'b1;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // sees the pre-edge values of the others, exactly like the hardware.
      case (state)
        IDLE: begin
          if (vcount == V_LAST && hcount == '0) begin
            state <= SAMPLE;
            retry <= '0;
          end
        end
        SAMPLE: begin
          t[0]  <= hc0;
          t[1]  <= hc1;
          t[2]  <= hc2;
          state <= CHECK;
        end
        CHECK: begin
          if (hc_match) begin
            state <= COMMIT;
          end else if (retry == MAX_FAIL) begin
            state     <= IDLE;
            pos_stale <= 1'b1;
          end else begin
            retry <= retry + 3'd1;
            state <= SAMPLE;
          end
        end
        COMMIT: begin
          for (int k = 0; k < 3; k++) s[k] <= t[k];
          pos_stale <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [11:0]       x_ext;
  logic [11:0]       x_plus_w;
  logic [10:0]       y_ext;
  logic [2:0]        box_next;
  logic [C_BITS-1:0] c_next [3];
  logic [R_BITS-1:0] r_next [3];

  assign x_ext    = {2'b00, hcount};
  assign x_plus_w = x_ext + W12;
  assign y_ext    = {1'b0, vcount};

  // Column test is done as x < s and x + W >= s, so no negative left edge
  // is ever formed; s == 0 naturally covers nothing.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    box_next = '0;
    for (int k = 0; k < 3; k++) begin
      c_next[k] = '0;
      r_next[k] = '0;
    end
    for (int k = 0; k < 3; k++) begin
      box_next[k] = (s[k] != PARK)
                 && ({1'b0, s[k]} < HIDE_X)
                 && (x_ext < {1'b0, s[k]})
                 && (x_plus_w >= {1'b0, s[k]})
                 && (y_ext >= Y_TOP[k])
                 && (y_ext < Y_TOP[k] + H11);
      c_next[k] = C_BITS'(x_plus_w - {1'b0, s[k]});
      r_next[k] = R_BITS'(y_ext - Y_TOP[k]);
    end
  end

  logic [2:0]        box1;
  logic [C_BITS-1:0] c1 [3];
  logic [R_BITS-1:0] r1 [3];
  logic              vo1;

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      box1 <= '0;
      vo1  <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        c1[k] <= '0;
        r1[k] <= '0;
      end
    end else begin
      box1 <= box_next;
      vo1  <= video_on;
      for (int k = 0; k < 3; k++) begin
        c1[k] <= c_next[k];
        r1[k] <= r_next[k];
      end
    end
  end

  function automatic logic sprite_on(input logic [R_BITS-1:0] r, input logic [C_BITS-1:0] c);
    if (r < 4'd4)      return (c >= 6'd16) && (c <= 6'd31);
    else if (r < 4'd8) return (c >= 6'd8)  && (c <= 6'd39);
    else               return (c <= 6'd47);
  endfunction

  logic [2:0] hit;

  always_comb begin
    hit = '0;
    for (int k = 0; k < 3; k++) hit[k] = box1[k] && sprite_on(r1[k], c1[k]);
  end

  // Lowest index wins where clouds overlap.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      cloud_pix  <= 1'b0;
      cloud_id   <= 2'd3;
      video_on_d <= 1'b0;
    end else begin
      video_on_d <= vo1;
      cloud_pix  <= vo1 && (|hit);
      if (!vo1)        cloud_id <= 2'd3;
      else if (hit[0]) cloud_id <= 2'd0;
      else if (hit[1]) cloud_id <= 2'd1;
      else if (hit[2]) cloud_id <= 2'd2;
      else             cloud_id <= 2'd3;
    end
  end

endmodule
